// File: rtl/unified_mmio_memory_if.sv
// -----------------------------------------------------------------------------
// unified_mmio_memory_if
//   Bus bundle for unified_mmio_memory. It holds the two memory ports (A: load/
//   store, B: instruction fetch), the output-FIFO byte stream (valid/ready) and
//   the status outputs.
//   modport master : the side that drives the ports and consumes the stream.
//   modport slave  : the memory itself.
// -----------------------------------------------------------------------------
interface unified_mmio_memory_if;
  // port A
  logic        en_a;
  logic [3:0]  we_a;
  logic [31:0] addr_a;
  logic [31:0] din_a;
  logic [31:0] dout_a;
  // port B
  logic        en_b;
  logic [3:0]  we_b;
  logic [31:0] addr_b;
  logic [31:0] din_b;
  logic [31:0] dout_b;
  // output byte stream and status
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        out_overflow;
  logic        init_busy;

  modport master (
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b,
    output out_ready,
    input  dout_a, dout_b, out_valid, out_data, out_overflow, init_busy
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b,
    input  out_ready,
    output dout_a, dout_b, out_valid, out_data, out_overflow, init_busy
  );
endinterface

// File: rtl/unified_mmio_memory.sv
// -----------------------------------------------------------------------------
// unified_mmio_memory
//   Flat 32-bit word memory with two byte-maskable read/write ports. Reads are
//   registered and read-first. Port A also decodes an 8-byte MMIO window:
//     MMIO_BASE+0 AVAI         : read = free FIFO slots, writes ignored
//     MMIO_BASE+4 OUTPUT_BYTES : write pushes din_a[7:0] into the byte FIFO,
//                                read returns 0
//   The FIFO drains through out_valid/out_data/out_ready. A push into a full
//   FIFO (with no pop in the same cycle) is dropped and sets sticky
//   out_overflow.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    unified_mmio_memory_if.slave (ports A/B, output stream, status)
//
// Optional feature (macro UNIFIED_MEM_CLEAR_EN):
//   After reset the memory is swept to zero, one word per cycle. While the
//   sweep runs init_busy is high, all port accesses are ignored and both
//   read outputs stay 0. Without the macro init_busy is tied low and the ports
//   are usable immediately after reset.
// -----------------------------------------------------------------------------
module unified_mmio_memory #(
  parameter int unsigned MEMORY_DEPTH_IN_WORD = 4096,
  parameter int unsigned OUT_FIFO_DEPTH       = 16,
  parameter logic [31:0] MMIO_BASE            = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mmio_memory_if.slave  bus
);

  localparam int unsigned AW = $clog2(MEMORY_DEPTH_IN_WORD);
  localparam int unsigned PW = $clog2(OUT_FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL = (PW+1)'(OUT_FIFO_DEPTH);

  typedef logic [AW-1:0] word_idx_t;

  // NOTE: the storage arrays carry no reset; only control state and the read
  // registers are reset, so the arrays map onto plain RAM.
  logic [31:0] mem      [MEMORY_DEPTH_IN_WORD];
  logic [7:0]  fifo_mem [OUT_FIFO_DEPTH];

  logic [31:0]   dout_a_q, dout_a_d;
  logic [31:0]   dout_b_q, dout_b_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic      busy;       // sweep in progress: ports are ignored
  logic      sweep_we;   // sweep writes one zero word this cycle
  word_idx_t sweep_idx;

  // ---------------------------------------------------------------------------
  // Clear sweep
  // ---------------------------------------------------------------------------
`ifdef UNIFIED_MEM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} sweep_state_e;

  sweep_state_e state_q, state_d;
  word_idx_t    sweep_idx_q, sweep_idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (state_q == ST_CLEAR) begin
      sweep_idx_d = sweep_idx_q + AW'(1);
      // Leave the sweep on the same edge that clears the last word.
      if (sweep_idx_q == word_idx_t'(MEMORY_DEPTH_IN_WORD - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    busy      = (state_q == ST_CLEAR);
    // The first edge without reset clears word 0.
    sweep_we  = (state_q == ST_CLEAR) && !reset;
    sweep_idx = sweep_idx_q;
  end
`else
  assign busy      = 1'b0;
  assign sweep_we  = 1'b0;
  assign sweep_idx = '0;
`endif

  // ---------------------------------------------------------------------------
  // Address decode and FIFO control
  // ---------------------------------------------------------------------------
  word_idx_t idx_a, idx_b;
  logic      mmio_a, mmio_b;
  logic      wr_a, wr_b;
  logic      push_req, push_ok, pop;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    idx_a    = bus.addr_a[AW+1:2];
    idx_b    = bus.addr_b[AW+1:2];
    mmio_a   = (bus.addr_a[31:3] == MMIO_BASE[31:3]);
    mmio_b   = (bus.addr_b[31:3] == MMIO_BASE[31:3]);
    // Port B never reaches MMIO; its accesses in the window are dropped.
    wr_a     = bus.en_a && !mmio_a && !busy;
    wr_b     = bus.en_b && !mmio_b && !busy;
    push_req = bus.en_a && mmio_a && bus.addr_a[2] && (|bus.we_a) && !busy;
    pop      = (count_q != '0) && bus.out_ready;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    push_ok  = push_req && ((count_q != FIFO_FULL) || pop);
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
    overflow_d = overflow_q || (push_req && !push_ok);
  end

  // Read data: registered, read-first, held while en is low.
  always_comb begin
    dout_a_d = dout_a_q;
    if (busy) begin
      dout_a_d = '0;
    end else if (bus.en_a) begin
      if (!mmio_a) begin
        dout_a_d = mem[idx_a];
      end else if (!bus.addr_a[2]) begin
        dout_a_d = 32'(FIFO_FULL - count_q);   // AVAI, pre-edge count
      end else begin
        dout_a_d = '0;                          // OUTPUT_BYTES reads as 0
      end
    end
  end

  always_comb begin
    dout_b_d = dout_b_q;
    if (busy) begin
      dout_b_d = '0;
    end else if (bus.en_b) begin
      dout_b_d = mmio_b ? '0 : mem[idx_b];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        // NOTE: both writes are non-blocking in one block, so when A and B hit
        // the same byte the later statement (port A) is the one that lands.
        if (wr_b && bus.we_b[i]) mem[idx_b][8*i +: 8] <= bus.din_b[8*i +: 8];
        if (wr_a && bus.we_a[i]) mem[idx_a][8*i +: 8] <= bus.din_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= bus.din_a[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a_q   <= '0;
      dout_b_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      dout_a_q   <= dout_a_d;
      dout_b_q   <= dout_b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.dout_a       = dout_a_q;
  assign bus.dout_b       = dout_b_q;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_data     = fifo_mem[rd_ptr_q];
  assign bus.out_overflow = overflow_q;
  assign bus.init_busy    = busy;

  // Byte-offset bits do not select anything in a word memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_a[1:0], bus.addr_b[1:0]};

endmodule

// File: tb/tb_unified_mmio_memory.sv
// -----------------------------------------------------------------------------
// tb_unified_mmio_memory
//   Scoreboard bench for unified_mmio_memory (64-word memory, 16-byte FIFO).
//   Expected read data and expected stream bytes are queued when stimulus is
//   driven and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_unified_mmio_memory;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          FD    = 16;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  unified_mmio_memory_if bus ();

  unified_mmio_memory #(
    .MEMORY_DEPTH_IN_WORD (DEPTH),
    .OUT_FIFO_DEPTH       (FD),
    .MMIO_BASE            (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_a_q   [$];
  logic [31:0] exp_b_q   [$];
  logic [7:0]  exp_out_q [$];   // bytes the FIFO should emit, in order
  logic        m_ovf = 1'b0;
  logic        sweep_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on both ports. ca/cb queue an expected read value
  // that is compared one edge later. The stream is checked before the edge.
  task automatic cycle(input logic ea, input logic [3:0] wa, input logic [31:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [31:0] ab, input logic [31:0] db,
                       input logic ca, input logic [31:0] xa, input logic cb, input logic [31:0] xb);
    logic pop_m, push_m;
    bus.en_a = ea; bus.we_a = wa; bus.addr_a = aa; bus.din_a = da;
    bus.en_b = eb; bus.we_b = wb; bus.addr_b = ab; bus.din_b = db;
    if (ca) exp_a_q.push_back(xa);
    if (cb) exp_b_q.push_back(xb);
    check("out_valid", 32'(bus.out_valid), 32'(exp_out_q.size() != 0));
    pop_m = (exp_out_q.size() != 0) && bus.out_ready;
    if (pop_m) check("out_data", 32'(bus.out_data), 32'(exp_out_q.pop_front()));
    push_m = ea && (aa[31:3] == BASE[31:3]) && aa[2] && (wa != 4'h0) && !sweep_active;
    if (push_m) begin
      if (exp_out_q.size() < FD) exp_out_q.push_back(da[7:0]);
      else                       m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check("out_overflow", 32'(bus.out_overflow), 32'(m_ovf));
    if (ca) check("dout_a", bus.dout_a, exp_a_q.pop_front());
    if (cb) check("dout_b", bus.dout_b, exp_b_q.pop_front());
    bus.en_a = 1'b0; bus.we_a = '0;
    bus.en_b = 1'b0; bus.we_b = '0;
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    cycle(1'b1, we, a, d, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] x);
    cycle(1'b1, '0, a, '0, 1'b0, '0, '0, '0, 1'b1, x, 1'b0, '0);
  endtask

  task automatic rd_b(input logic [31:0] a, input logic [31:0] x);
    cycle(1'b0, '0, '0, '0, 1'b1, '0, a, '0, 1'b0, '0, 1'b1, x);
  endtask

  task automatic do_reset(input int n);
    bus.en_a = 1'b0; bus.we_a = '0; bus.en_b = 1'b0; bus.we_b = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("rst_dout_a", bus.dout_a, '0);
    check("rst_dout_b", bus.dout_b, '0);
    check("rst_out_valid", 32'(bus.out_valid), '0);
    check("rst_out_overflow", 32'(bus.out_overflow), '0);
`ifdef UNIFIED_MEM_CLEAR_EN
    check("rst_init_busy", 32'(bus.init_busy), 32'd1);
`endif
    reset = 1'b0;
    exp_out_q.delete();
    m_ovf = 1'b0;
  endtask

`ifdef UNIFIED_MEM_CLEAR_EN
  // Counts edges until init_busy drops; bounded so a stuck sweep still ends.
  task automatic wait_sweep(output int n);
    n = 0;
    while (bus.init_busy === 1'b1 && n < 4 * DEPTH) begin
      idle();
      n++;
    end
  endtask
`endif

  task automatic settle();
`ifdef UNIFIED_MEM_CLEAR_EN
    int n;
    sweep_active = 1'b1;
    wait_sweep(n);
    sweep_active = 1'b0;
    check("sweep_len", 32'(n), 32'(DEPTH));
`else
    check("init_busy_low", 32'(bus.init_busy), '0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.en_a = 1'b0; bus.we_a = '0; bus.addr_a = '0; bus.din_a = '0;
    bus.en_b = 1'b0; bus.we_b = '0; bus.addr_b = '0; bus.din_b = '0;
    bus.out_ready = 1'b0;

    // Reset held for several cycles.
    do_reset(3);
    settle();

    // Word write, read, then partial merge.
    wr_a(32'h10, 4'hF, 32'hDEAD_BEEF);
    rd_a(32'h10, 32'hDEAD_BEEF);
    wr_a(32'h10, 4'b0010, 32'h0000_5500);
    rd_a(32'h10, 32'hDEAD_55EF);

    // Read-during-write on one port returns the old word.
    cycle(1'b1, 4'hF, 32'h10, 32'h0102_0304, 1'b0, '0, '0, '0, 1'b1, 32'hDEAD_55EF, 1'b0, '0);
    rd_a(32'h10, 32'h0102_0304);

    // Same-word collision: A wins its bytes, B fills the rest.
    cycle(1'b1, 4'b0011, 32'h20, 32'h1111_1111, 1'b1, 4'hF, 32'h20, 32'h2222_2222,
          1'b0, '0, 1'b0, '0);
    rd_b(32'h20, 32'h2222_1111);
    rd_a(32'h20, 32'h2222_1111);

    // Cross-port read of a word written this cycle sees the old word.
    wr_a(32'h30, 4'hF, 32'h0BAD_F00D);
    cycle(1'b1, 4'hF, 32'h30, 32'hCAFE_F00D, 1'b1, '0, 32'h30, '0, 1'b0, '0, 1'b1, 32'h0BAD_F00D);
    rd_b(32'h30, 32'hCAFE_F00D);

    // Aliasing of high bits and ignored byte offset.
    wr_a(32'h140, 4'hF, 32'h600D_CAFE);
    rd_a(32'h43, 32'h600D_CAFE);
    idle();
    check("hold_dout_a", bus.dout_a, 32'h600D_CAFE);

    // Port B in the MMIO window: no push, no memory write, reads 0.
    wr_a(32'h04, 4'hF, 32'h1357_9BDF);
    rd_b(32'h20, 32'h2222_1111);
    cycle(1'b0, '0, '0, '0, 1'b1, 4'hF, BASE + 32'h4, 32'h55, 1'b0, '0, 1'b0, '0);
    rd_b(BASE, 32'h0);
    check("b_mmio_no_push", 32'(bus.out_valid), '0);
    rd_a(32'h04, 32'h1357_9BDF);

    // Fill to 16, check AVAI, overflow on the 17th.
    rd_a(BASE, 32'(FD));
    for (int i = 0; i < 16; i++) wr_a(BASE + 32'h4, 4'h1, 32'(i));
    rd_a(BASE, 32'h0);
    wr_a(BASE + 32'h4, 4'h1, 32'h10);
    check("overflow_set", 32'(bus.out_overflow), 32'd1);
    rd_a(BASE + 32'h4, 32'h0);
    wr_a(BASE, 4'hF, 32'h12);
    rd_a(BASE, 32'h0);
    rd_a(32'h04, 32'h1357_9BDF);

    // Drain: 0x00..0x0F in order.
    bus.out_ready = 1'b1;
    repeat (16) idle();
    check("drained", 32'(bus.out_valid), '0);
    check("drain_overflow_sticky", 32'(bus.out_overflow), 32'd1);
    rd_a(BASE, 32'(FD));

    // Push with ready into an empty FIFO: only the push applies.
    wr_a(BASE + 32'h4, 4'h1, 32'h5A);
    idle();
    idle();

    // Full FIFO, simultaneous push and pop.
    do_reset(1);
    settle();
    for (int i = 0; i < 16; i++) wr_a(BASE + 32'h4, 4'h1, 32'h40 + 32'(i));
    bus.out_ready = 1'b1;
    wr_a(BASE + 32'h4, 4'h1, 32'hAA);
    bus.out_ready = 1'b0;
    rd_a(BASE, 32'h0);
    check("full_pushpop_no_ovf", 32'(bus.out_overflow), '0);
    bus.out_ready = 1'b1;
    repeat (16) idle();
    check("full_drained", 32'(bus.out_valid), '0);
    bus.out_ready = 1'b0;

`ifdef UNIFIED_MEM_CLEAR_EN
    begin
      int n;
      wr_a(32'h14, 4'hF, 32'h1234_5678);
      rd_a(32'h14, 32'h1234_5678);
      do_reset(1);
      sweep_active = 1'b1;
      repeat (9) idle();
      // Sweep cycle 10: both ports try to write already-cleared words.
      cycle(1'b1, 4'hF, 32'h00, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'h04, 32'hFFFF_FFFF,
            1'b1, 32'h0, 1'b1, 32'h0);
      wr_a(BASE + 32'h4, 4'h1, 32'h77);
      wait_sweep(n);
      sweep_active = 1'b0;
      check("sweep_len_busy_writes", 32'(11 + n), 32'(DEPTH));
      rd_a(32'h14, 32'h0);
      rd_a(32'h00, 32'h0);
      rd_b(32'h04, 32'h0);

      // Reset in the middle of the sweep restarts it.
      do_reset(1);
      sweep_active = 1'b1;
      repeat (29) idle();
      check("busy_mid_sweep", 32'(bus.init_busy), 32'd1);
      do_reset(1);
      wait_sweep(n);
      sweep_active = 1'b0;
      check("sweep_len_restart", 32'(n), 32'(DEPTH));
    end
`endif

    check("scoreboard_empty", 32'(exp_out_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
